// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: 2-flop input sync, 16x oversampled bit timing, start/stop validation.
// Define UART_RX_MAJORITY_EN to vote each bit from samples at ticks 6/7/8 instead of a single tick-7 sample.
module uart_rx_deserializer #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       framing_error,
  output logic       busy
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] SAMPLE_PT = 4'd8;
`else
  localparam logic [3:0] SAMPLE_PT = 4'd7;
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state;
  logic             rx_meta;
  logic             rx_s;
  logic             rx_prev;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       tick_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             tick;
  logic             is_sample;
  logic             sample_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign tick      = (div_cnt == DIV_LAST);
  assign is_sample = tick && (tick_cnt == SAMPLE_PT);

`ifdef UART_RX_MAJORITY_EN
  logic s6;
  logic s7;

  // Early samples are held so the vote can complete on the tick-8 sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      s6 <= 1'b1;
      s7 <= 1'b1;
    end else if (tick) begin
      if (tick_cnt == 4'd6) s6 <= rx_s;
      if (tick_cnt == 4'd7) s7 <= rx_s;
    end
  end

  assign sample_bit = (s6 & s7) | (s6 & rx_s) | (s7 & rx_s);
`else
  assign sample_bit = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      div_cnt       <= '0;
      tick_cnt      <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      div_cnt       <= tick ? '0 : div_cnt + 1'b1;
      if (tick) tick_cnt <= tick_cnt + 4'd1;

      case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            state    <= START;
            div_cnt  <= '0;
            tick_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        // A genuine start bit runs to tick 15; the 4-bit wrap zeroes tick_cnt for DATA.
        START: begin
          if (is_sample && sample_bit) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (tick && tick_cnt == 4'd15) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (is_sample) shreg[bit_idx] <= sample_bit;
          if (tick && tick_cnt == 4'd15) begin
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 3'd1;
          end
        end
        STOP: begin
          if (is_sample) begin
            if (sample_bit) begin
              data_out   <= shreg;
              data_valid <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              framing_error <= 1'b1;
              state         <= WAIT_IDLE;
            end
          end
        end
        // Hold off until the line recovers so a break is not seen as repeated starts.
        WAIT_IDLE: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer: serial frames are driven at the default baud and
// expected strobes are queued at drive time, then matched by a monitor as the DUT produces them.
module tb_uart_rx_deserializer;

  localparam int BIT_CLKS = (50_000_000 / (115200 * 16)) * 16;

  typedef struct packed {
    logic       fe;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       framing_error;
  logic       busy;

  exp_t       exp_q[$];
  int         checks;
  int         errors;
  logic [7:0] last_good;

  uart_rx_deserializer dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .framing_error(framing_error),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drives one 8N1 frame, bit edges on negedges; optional 1-clk inversion at each data bit centre.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_val, input logic glitch,
                               input logic [7:0] exp_data);
    logic [9:0] frame;
    exp_t       e;
    frame  = {stop_val, b, 1'b0};
    e.fe   = ~stop_val;
    e.data = stop_val ? exp_data : 8'h00;
    exp_q.push_back(e);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx = frame[i];
      if (glitch && i >= 1 && i <= 8) begin
        repeat (BIT_CLKS / 2) @(negedge clk);
        rx = ~frame[i];
        @(negedge clk);
        rx = frame[i];
        repeat (BIT_CLKS / 2 - 2) @(negedge clk);
      end else begin
        repeat (BIT_CLKS - 1) @(negedge clk);
      end
    end
    if (stop_val) last_good = exp_data;
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Every strobe must be single-cycle, exclusive, and match the head of the queue.
  initial begin : monitor
    exp_t e;
    logic strobe_prev;
    strobe_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (data_valid || framing_error) begin
        checkOutput("strobe_width", 32'(strobe_prev), 32'd0);
        checkOutput("strobe_exclusive", 32'(data_valid && framing_error), 32'd0);
        checkOutput("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checkOutput("strobe_kind_fe", 32'(framing_error), 32'(e.fe));
          if (e.fe) checkOutput("fe_data_hold", 32'(data_out), 32'(last_good));
          else checkOutput("rx_data", 32'(data_out), 32'(e.data));
        end
      end
      strobe_prev = data_valid || framing_error;
    end
  end

  initial begin
    logic [7:0] b2b [3];
    logic [7:0] aborted;
    checks    = 0;
    errors    = 0;
    last_good = 8'h00;
    reset     = 1'b1;
    rx        = 1'b1;
    b2b       = '{8'h00, 8'hFF, 8'h55};
    aborted   = 8'hA5;

    repeat (3) @(negedge clk);
    checkOutput("rst_data_out", 32'(data_out), 32'd0);
    checkOutput("rst_data_valid", 32'(data_valid), 32'd0);
    checkOutput("rst_framing_error", 32'(framing_error), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (50) @(negedge clk);

    $display("[TB] single byte 0xAA");
    applyStimulus(8'hAA, 1'b1, 1'b0, 8'hAA);
    waitDrain(6000);
    checkOutput("busy_after_aa", 32'(busy), 32'd0);

    $display("[TB] back-to-back bytes");
    foreach (b2b[i]) applyStimulus(b2b[i], 1'b1, 1'b0, b2b[i]);
    waitDrain(6000);

    $display("[TB] stop bit held low");
    applyStimulus(8'h3C, 1'b0, 1'b0, 8'h00);
    repeat (2 * BIT_CLKS) @(negedge clk);
    checkOutput("busy_wait_idle", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("busy_released", 32'(busy), 32'd0);
    checkOutput("data_after_fe", 32'(data_out), 32'h55);
    waitDrain(100);
    repeat (100) @(negedge clk);

    $display("[TB] false start");
    @(negedge clk);
    rx = 1'b0;
    repeat (81) @(negedge clk);
    rx = 1'b1;
    checkOutput("busy_false_start", 32'(busy), 32'd1);
    repeat (200) @(negedge clk);
    checkOutput("busy_after_false", 32'(busy), 32'd0);
    repeat (4500) @(negedge clk);

    $display("[TB] reset mid-frame");
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = aborted[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = aborted[4];
    repeat (100) @(negedge clk);
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_good = 8'h00;
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    checkOutput("rst_mid_data", 32'(data_out), 32'd0);
    repeat (2 * BIT_CLKS) @(negedge clk);
    applyStimulus(8'h5A, 1'b1, 1'b0, 8'h5A);
    waitDrain(6000);

    $display("[TB] glitched data bits");
`ifdef UART_RX_MAJORITY_EN
    applyStimulus(8'h0F, 1'b1, 1'b1, 8'h0F);
`else
    applyStimulus(8'h0F, 1'b1, 1'b1, 8'hF0);
`endif
    waitDrain(6000);
    repeat (50) @(negedge clk);
    checkOutput("busy_final", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
